sample_window_loader: RTL and testbench
=======================================

// Module: sample_window_loader
// PURPOSE
//  Streaming front end for the pipelined adder tree. Collects serial samples (valid/ready)
//  into an INPUTS_NUM-wide parallel window that drives the tree's idata.
//  Emits a one-cycle frame strobe, plus a matching sum-valid strobe delayed by the tree latency.
//  With that strobe, downstream logic knows which cycle of the tree output to capture.
// PARAMETERS
//  INPUTS_NUM    125                  samples per window; any value >= 2, not required to be 2^n
//  IDATA_WIDTH   16                   sample width, bits
//  TREE_LATENCY  $clog2(INPUTS_NUM)   clocks from win_data change to valid tree odata
//  FILL_W        $clog2(INPUTS_NUM+1) width of fill_level (derived, do not override)
// PORTS
//  clk         in   1                         clock
//  nrst        in   1                         synchronous reset, active-low
//  s_valid     in   1                         input sample valid
//  s_ready     out  1                         block accepts sample when s_valid & s_ready
//  s_data      in   IDATA_WIDTH               input sample
//  flush       in   1                         close partial frame, zero-pad unfilled slots
//  win_data    out  INPUTS_NUM x IDATA_WIDTH  packed window to adder tree idata
//  win_valid   out  1                         one-cycle strobe: new window on win_data
//  sum_valid   out  1                         win_valid delayed TREE_LATENCY clks; tree odata valid
//  fill_level  out  FILL_W                    samples held in the collecting buffer
// BEHAVIOUR
//  - Reset (nrst=0 at posedge): win_data=0, win_valid=0, sum_valid=0, fill_level=0.
//    s_ready=0 while nrst=0. FSM->FILL. Delay line cleared.
//    Reset mid-frame discards the partial frame; no strobes follow.
//  - Double buffer: collect buffer (internal) + output register (win_data).
//    win_data stays stable between win_valid strobes. Tree input never glitches mid-frame.
//  - FSM states: FILL, FLUSH.
//    FILL: s_ready=1. On accept, s_data -> collect[fill_level]; fill_level++.
//          Ordering: first sample of frame -> index 0.
//          Accept bringing fill_level to INPUTS_NUM:
//            collect -> win_data and win_valid=1 next cycle; fill_level->0; stay FILL.
//          Back-to-back frames run at full rate, with no bubble.
//    FILL + flush=1 with fill_level>0 (after any same-cycle accept): -> FLUSH.
//    FLUSH: s_ready=0 for exactly one cycle.
//           Collect -> win_data with slots >= fill_level forced to 0; win_valid=1 next cycle.
//           fill_level->0; -> FILL.
//  - Simultaneous events:
//    - flush + accept in one cycle: sample is stored first, then flush applies to it.
//    - If that accept completes the frame: normal emit, flush is a no-op.
//    - flush with fill_level=0 and no accept: no-op, no strobe.
//  - Latency: final accept at edge t -> win_valid high in cycle t+1 -> sum_valid high in cycle
//    t+1+TREE_LATENCY. Exactly one sum_valid per win_valid; strobes may overlap in flight.
//  - No arithmetic on data. fill_level never exceeds INPUTS_NUM.
// CONFIGURATION
//  SAMPLE_WINDOW_SLIDING_EN defined: sliding-window (moving-sum) mode.
//    - Collect buffer is a shift register: oldest at index 0, newest at INPUTS_NUM-1.
//    - Each accept shifts the window by one.
//    - fill_level saturates at INPUTS_NUM.
//    - Once saturated, every accept copies the window to win_data and strobes win_valid next cycle.
//    - flush clears the window to 0 and fill_level to 0, with no strobe. FLUSH state is unused.
//  Not defined: block-frame mode as above.
// STRUCTURE
//  - Package sample_window_pkg: state_t enum {FILL, FLUSH}; FILL_W helper function.
//  - Sub-module valid_delay_line #(.DEPTH(TREE_LATENCY)): win_valid -> sum_valid bit shift register.
//    Synchronous clear on nrst=0.
//  - Top: FSM, collect buffer, output register, fill counter.
// TESTING  (INPUTS_NUM=5, IDATA_WIDTH=8, TREE_LATENCY=3)
//  - Basic frame:
//    - 5 accepts 1..5 back-to-back -> win_valid 1 cycle later, win_data={5,4,3,2,1}.
//    - sum_valid exactly 3 cycles after win_valid. Tree model sum=15.
//  - Streaming: 15 continuous samples, s_valid=1 -> three win_valid strobes 5 cycles apart.
//    s_ready stays 1 throughout. Sums 15,40,65 for data 1..15.
//  - Flush: 3 samples 7,8,9 then flush -> s_ready=0 one cycle.
//    win_data={0,0,9,8,7}, sum 24.
//    Then flush with fill_level=0 -> no strobe.
//  - Flush + accept collision: on the 5th sample, flush=1 -> single normal frame.
//    No FLUSH cycle, no extra strobe.
//  - Reset mid-frame: 3 samples, nrst=0 one cycle, win_valid in flight -> outputs 0.
//    No sum_valid after reset. Next frame is correct.
//  - Sliding mode (SAMPLE_WINDOW_SLIDING_EN): samples 1..7 -> strobes on samples 5,6,7.
//    Windows sum 15,20,25.

Source files
------------

// File: rtl/sample_window_loader_pkg.sv
// Shared types and helpers for the sample window loader: FSM state encoding
// and the fill-counter width derivation.
package sample_window_pkg;

  typedef enum logic {FILL, FLUSH} state_t;

  // fill_level must represent 0..n inclusive
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sample_window_loader_if.sv
// Stream-in / window-out bundle between a sample source, the window loader
// and the adder tree front end.
interface sample_window_loader_if #(
  parameter int INPUTS_NUM  = 125,
  parameter int IDATA_WIDTH = 16
);
  import sample_window_pkg::*;

  localparam int FILL_W = fill_w(INPUTS_NUM);

  logic                                    s_valid;
  logic                                    s_ready;
  logic [IDATA_WIDTH-1:0]                  s_data;
  logic                                    flush;
  logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0]  win_data;
  logic                                    win_valid;
  logic                                    sum_valid;
  logic [FILL_W-1:0]                       fill_level;

  modport master (
    output s_valid, s_data, flush,
    input  s_ready, win_data, win_valid, sum_valid, fill_level
  );

  modport slave (
    input  s_valid, s_data, flush,
    output s_ready, win_data, win_valid, sum_valid, fill_level
  );

endinterface

// File: rtl/sample_window_loader_delay.sv
// Bit shift register that delays the window strobe by the adder tree latency
// so it lines up with valid tree output.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic dout
);

  logic [DEPTH:0] vld_pipe;
  logic [DEPTH:1] pipe_q;

  assign vld_pipe = {pipe_q, din};
  assign dout     = vld_pipe[DEPTH];

  always_ff @(posedge clk) begin
    if (!nrst) pipe_q <= '0;
    else       pipe_q <= vld_pipe[DEPTH-1:0];
  end

endmodule

// File: rtl/sample_window_loader.sv
// Collects serial samples into a parallel window for the adder tree.
// Define SAMPLE_WINDOW_SLIDING_EN for sliding-window (moving-sum) mode.
module sample_window_loader
  import sample_window_pkg::*;
#(
  parameter int INPUTS_NUM   = 125,
  parameter int IDATA_WIDTH  = 16,
  parameter int TREE_LATENCY = $clog2(INPUTS_NUM)
) (
  input  logic                 clk,
  input  logic                 nrst,
  sample_window_loader_if.slave io
);

  localparam int FILL_W = fill_w(INPUTS_NUM);

  typedef logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] win_t;

  state_t            state, state_nxt;
  win_t              collect, coll_nxt;
  win_t              win_q, win_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic              emit, win_vld, accept;

  assign io.s_ready    = nrst && (state == FILL);
  assign accept        = io.s_valid && io.s_ready;
  assign io.win_data   = win_q;
  assign io.win_valid  = win_vld;
  assign io.fill_level = fill;

  always_ff @(posedge clk) begin
    if (!nrst) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    coll_nxt  = collect;
    fill_nxt  = fill;
    win_nxt   = win_q;
    emit      = 1'b0;
`ifdef SAMPLE_WINDOW_SLIDING_EN
    // clear wins over a same-cycle accept; oldest sample sits at index 0
    if (io.flush) begin
      coll_nxt = '0;
      fill_nxt = '0;
    end else if (accept) begin
      coll_nxt = {io.s_data, collect[INPUTS_NUM-1:1]};
      if (fill >= FILL_W'(INPUTS_NUM - 1)) begin
        emit     = 1'b1;
        win_nxt  = coll_nxt;
        fill_nxt = FILL_W'(INPUTS_NUM);
      end else begin
        fill_nxt = fill + FILL_W'(1);
      end
    end
`else
    case (state)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < INPUTS_NUM; i++)
            if (FILL_W'(i) == fill) coll_nxt[i] = io.s_data;
          // a completing accept emits normally and swallows any flush
          if (fill == FILL_W'(INPUTS_NUM - 1)) begin
            emit     = 1'b1;
            win_nxt  = coll_nxt;
            fill_nxt = '0;
          end else begin
            fill_nxt = fill + FILL_W'(1);
            if (io.flush) state_nxt = FLUSH;
          end
        end else if (io.flush && (fill != '0)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // slots past the fill point may hold a previous frame's data
        for (int i = 0; i < INPUTS_NUM; i++)
          win_nxt[i] = (FILL_W'(i) < fill) ? collect[i] : '0;
        emit      = 1'b1;
        fill_nxt  = '0;
        state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      collect <= '0;
      win_q   <= '0;
      fill    <= '0;
      win_vld <= 1'b0;
    end else begin
      collect <= coll_nxt;
      win_q   <= win_nxt;
      fill    <= fill_nxt;
      win_vld <= emit;
    end
  end

  valid_delay_line #(.DEPTH(TREE_LATENCY)) u_dly (
    .clk  (clk),
    .nrst (nrst),
    .din  (win_vld),
    .dout (io.sum_valid)
  );

endmodule

// File: tb/tb_sample_window_loader.sv
// Scoreboard bench for sample_window_loader: stimulus queues expected windows,
// a negedge monitor checks each win_valid / sum_valid strobe against them.
module tb_sample_window_loader;
  import sample_window_pkg::*;

  localparam int N = 5;
  localparam int W = 8;
  localparam int L = 3;

  typedef logic [N-1:0][W-1:0] win_t;
  typedef struct {win_t win; int sum; bit chk_sum;} exp_t;
  typedef struct {int sum; int at;} sum_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  sample_window_loader_if #(.INPUTS_NUM(N), .IDATA_WIDTH(W)) ifc ();

  sample_window_loader #(.INPUTS_NUM(N), .IDATA_WIDTH(W), .TREE_LATENCY(L)) dut (
    .clk  (clk),
    .nrst (nrst),
    .io   (ifc)
  );

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   stalls = 0;
  exp_t exp_win_q[$];
  sum_t exp_sum_q[$];
  int   win_cyc[$];
  int   tree_pipe[L];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endfunction

  function automatic win_t mkwin(input int base);
    win_t w;
    for (int i = 0; i < N; i++) w[i] = W'(base + i);
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // monitor + tree model (sum of win_data, L cycles late)
  always @(negedge clk) begin
    int   s;
    exp_t e;
    sum_t x;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(ifc.win_data[i]);
    if (ifc.win_valid === 1'b1) begin
      win_cyc.push_back(cyc);
      if (exp_win_q.size() == 0) check("unexpected_win_valid", 1, 0);
      else begin
        e = exp_win_q.pop_front();
        check("win_data", ifc.win_data, e.win);
        if (e.chk_sum) exp_sum_q.push_back('{e.sum, cyc + L});
      end
    end
    if (ifc.sum_valid === 1'b1) begin
      if (exp_sum_q.size() == 0) check("unexpected_sum_valid", 1, 0);
      else begin
        x = exp_sum_q.pop_front();
        check("tree_sum", tree_pipe[L-1], x.sum);
        check("sum_valid_cycle", cyc, x.at);
      end
    end
    for (int i = L - 1; i > 0; i--) tree_pipe[i] = tree_pipe[i-1];
    tree_pipe[0] = s;
  end

  task automatic send(input int d, input bit fl);
    int n;
    n = 0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = W'(d);
    ifc.flush   = fl;
    while (ifc.s_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("send_timeout", 0, 1);
    stalls += n;
    @(posedge clk); #1;
    ifc.s_valid = 1'b0;
    ifc.flush   = 1'b0;
  endtask

  task automatic expect_frame(input win_t w, input int s, input bit cs);
    exp_t e;
    e.win = w; e.sum = s; e.chk_sum = cs;
    exp_win_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    win_t fw;
    int   k;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.flush   = 1'b0;
    nrst        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", ifc.s_ready, 0);
    check("rst_win_valid", ifc.win_valid, 0);
    check("rst_sum_valid", ifc.sum_valid, 0);
    check("rst_win_data", ifc.win_data, 0);
    check("rst_fill_level", ifc.fill_level, 0);
    nrst = 1'b1;
    #1;
    check("post_rst_s_ready", ifc.s_ready, 1);
    idle(1);

`ifndef SAMPLE_WINDOW_SLIDING_EN
    // basic frame
    expect_frame(mkwin(1), 15, 1);
    for (int d = 1; d <= 3; d++) send(d, 0);
    check("fill_level_3", ifc.fill_level, 3);
    send(4, 0);
    send(5, 0);
    check("win_valid_latency", ifc.win_valid, 1);
    check("fill_level_wrap", ifc.fill_level, 0);
    idle(6);

    // streaming, three back-to-back frames
    stalls = 0;
    k = win_cyc.size();
    expect_frame(mkwin(1), 15, 1);
    expect_frame(mkwin(6), 40, 1);
    expect_frame(mkwin(11), 65, 1);
    for (int d = 1; d <= 15; d++) send(d, 0);
    idle(6);
    check("stream_stalls", stalls, 0);
    if (win_cyc.size() >= k + 3) begin
      check("stream_gap_1", win_cyc[k+1] - win_cyc[k], 5);
      check("stream_gap_2", win_cyc[k+2] - win_cyc[k+1], 5);
    end else check("stream_strobe_count", win_cyc.size() - k, 3);

    // partial frame flush
    fw = '0;
    fw[0] = 8'd7; fw[1] = 8'd8; fw[2] = 8'd9;
    expect_frame(fw, 24, 1);
    send(7, 0); send(8, 0); send(9, 0);
    ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    check("flush_ready_low", ifc.s_ready, 0);
    @(posedge clk); #1;
    check("flush_ready_back", ifc.s_ready, 1);
    check("flush_win_valid", ifc.win_valid, 1);
    check("flush_fill_level", ifc.fill_level, 0);
    idle(6);

    // flush with empty buffer is a no-op
    ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    check("empty_flush_ready", ifc.s_ready, 1);
    @(posedge clk); #1;
    check("empty_flush_no_strobe", ifc.win_valid, 0);
    idle(6);

    // flush collides with the completing accept
    expect_frame(mkwin(1), 15, 1);
    for (int d = 1; d <= 4; d++) send(d, 0);
    send(5, 1);
    check("collide_ready", ifc.s_ready, 1);
    check("collide_fill", ifc.fill_level, 0);
    idle(6);

    // reset mid-frame
    send(11, 0); send(12, 0); send(13, 0);
    nrst = 1'b0;
    @(posedge clk); #1;
    check("midrst_fill", ifc.fill_level, 0);
    check("midrst_s_ready", ifc.s_ready, 0);
    nrst = 1'b1;
    #1;
    // frame whose sum strobe is killed by reset
    expect_frame(mkwin(1), 15, 0);
    for (int d = 1; d <= 5; d++) send(d, 0);
    nrst = 1'b0;
    @(posedge clk); #1;
    check("inflight_win_valid", ifc.win_valid, 0);
    check("inflight_win_data", ifc.win_data, 0);
    nrst = 1'b1;
    #1;
    idle(6);
    expect_frame(mkwin(21), 115, 1);
    for (int d = 21; d <= 25; d++) send(d, 0);
    idle(8);
`else
    // sliding window: strobes once saturated
    expect_frame(mkwin(1), 15, 1);
    expect_frame(mkwin(2), 20, 1);
    expect_frame(mkwin(3), 25, 1);
    for (int d = 1; d <= 7; d++) send(d, 0);
    check("slide_fill_sat", ifc.fill_level, 5);
    idle(6);
    ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    check("slide_flush_fill", ifc.fill_level, 0);
    check("slide_flush_no_strobe", ifc.win_valid, 0);
    idle(6);
`endif

    check("pending_windows", exp_win_q.size(), 0);
    check("pending_sums", exp_sum_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
